inst_encoder: RTL and testbench



---
 rtl/inst_enc_pkg.sv | 40 ++++
 rtl/inst_encoder_enc_pack.sv | 41 ++++
 rtl/inst_encoder.sv | 134 +++++++++++++
 tb/tb_inst_encoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package inst_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_req_t;

  // True when v[31:msb] are all equal, i.e. v sign-extends from bit msb.
  function automatic logic fits_signed(input logic [31:0] v, input int msb);
    logic [31:0] s;
    s = $signed(v) >>> msb;
    return (s == 32'h0) || (s == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/inst_encoder_enc_pack.sv
// Combinational RV32I field packer with per-format immediate range check.
module enc_pack
  import inst_enc_pkg::*;
(
  input  enc_req_t    req,
  output logic [31:0] inst,
  output logic        err
);

  always_comb begin
    inst = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
    err  = 1'b0;
    case (req.fmt)
      FMT_R: err = 1'b0;
      FMT_I: begin
        inst = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
        err  = !fits_signed(req.imm, 11);
      end
      FMT_S: begin
        inst = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
        err  = !fits_signed(req.imm, 11);
      end
      FMT_B: begin
        inst = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                req.imm[4:1], req.imm[11], req.opcode};
        err  = !fits_signed(req.imm, 12) || req.imm[0];
      end
      FMT_U: begin
        inst = {req.imm[31:12], req.rd, req.opcode};
        err  = (req.imm[11:0] != 12'h000);
      end
      FMT_J: begin
        inst = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, req.opcode};
        err  = !fits_signed(req.imm, 20) || req.imm[0];
      end
      // Undefined format codes keep the R packing but are flagged.
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: valid/ready input, registered output with a one-entry
// skid, wrapping write-address counter and saturating error counter.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [15:0] err_count
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  enc_req_t    req;
  logic [31:0] new_inst;
  logic        new_err;

  assign req = '{fmt: fmt_e'(in_fmt), opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                 rs2: in_rs2, funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  enc_pack u_pack (.req(req), .inst(new_inst), .err(new_err));

  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_inst_q,  out_inst_d;
  logic          out_err_q,   out_err_d;
  logic [AW-1:0] out_idx_q,   out_idx_d;
  logic [AW-1:0] load_idx_q,  load_idx_d;
  logic          skid_valid_q, skid_valid_d;
  logic [31:0]   skid_inst_q,  skid_inst_d;
  logic          skid_err_q,   skid_err_d;
  logic [15:0]   err_cnt_q,    err_cnt_d;

  logic accept, out_fire, out_free, load;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready & ~flush;
  assign out_fire = out_valid_q & out_ready;
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_inst_d   = out_inst_q;
    out_err_d    = out_err_q;
    out_idx_d    = out_idx_q;
    load_idx_d   = load_idx_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_err_d   = skid_err_q;
    err_cnt_d    = err_cnt_q;
    load         = 1'b0;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      out_idx_d    = '0;
      load_idx_d   = '0;
    end else begin
      if (out_fire && out_err_q && (err_cnt_q != 16'hFFFF))
        err_cnt_d = err_cnt_q + 16'd1;
      if (out_free) begin
        // Skid is older than any new input, and in_ready is low while it is full.
        if (skid_valid_q) begin
          load         = 1'b1;
          out_inst_d   = skid_inst_q;
          out_err_d    = skid_err_q;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          load       = 1'b1;
          out_inst_d = new_inst;
          out_err_d  = new_err;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_inst_d  = new_inst;
        skid_err_d   = new_err;
      end
      if (load) begin
        out_valid_d = 1'b1;
        out_idx_d   = load_idx_q;
        load_idx_d  = load_idx_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_inst_q   <= '0;
      out_err_q    <= 1'b0;
      out_idx_q    <= '0;
      load_idx_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      out_err_q    <= out_err_d;
      out_idx_q    <= out_idx_d;
      load_idx_q   <= load_idx_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_err_q   <= skid_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;
  assign out_addr  = BASE_ADDR + (32'(out_idx_q) << 2);
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vectors plus random traffic
// against a queue-based reference model.
module tb_inst_encoder;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst, out_addr;
  logic        out_err;
  logic [15:0] err_count;

  inst_encoder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  int   pushcnt = 0;
  int   m_errcnt = 0;
  int   errors = 0;
  int   checks = 0;
  bit   last_acc;

  function automatic logic [31:0] m_enc(input logic [2:0] f, input logic [31:0] op,
      input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
      input logic [31:0] f3, input logic [31:0] f7, input logic [31:0] imm);
    logic [31:0] common;
    common = (rs1 << 15) | (f3 << 12) | op;
    case (f)
      3'd1: return ((imm & 32'hFFF) << 20) | common | (rd << 7);
      3'd2: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | common | ((imm & 32'h1F) << 7);
      3'd3: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                   | common | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
      3'd4: return (imm & 32'hFFFF_F000) | (rd << 7) | op;
      3'd5: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
      default: return (f7 << 25) | (rs2 << 20) | common | (rd << 7);
    endcase
  endfunction

  function automatic logic m_err(input logic [2:0] f, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    case (f)
      3'd0: return 1'b0;
      3'd1, 3'd2: return (s < -2048) || (s > 2047);
      3'd3: return (s < -4096) || (s > 4095) || (imm % 2 != 0);
      3'd4: return (imm % 4096) != 0;
      3'd5: return (s < -1048576) || (s > 1048575) || (imm % 2 != 0);
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    in_valid = 1'b1; in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_funct7 = 7'h00; in_imm = imm;
  endtask

  // One clock: check state at negedge against the model, then advance the model.
  task automatic step();
    bit fire, acc;
    exp_t e;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("err_count", 32'(err_count), 32'(m_errcnt));
    if (q.size() > 0) begin
      chk("out_inst", out_inst, q[0].inst);
      chk("out_err", 32'(out_err), 32'(q[0].err));
      chk("out_addr", out_addr, q[0].addr);
    end
    fire = (q.size() > 0) && out_ready;
    acc  = in_valid && (q.size() < 2) && !flush;
    e.inst = m_enc(in_fmt, 32'(in_opcode), 32'(in_rd), 32'(in_rs1), 32'(in_rs2),
                   32'(in_funct3), 32'(in_funct7), in_imm);
    e.err  = m_err(in_fmt, in_imm);
    e.addr = BASE + 32'(4 * (pushcnt % DEPTH));
    @(posedge clk);
    if (flush) begin
      q.delete();
      pushcnt = 0;
      acc = 1'b0;
    end else begin
      if (fire) begin
        if (q[0].err && m_errcnt < 65535) m_errcnt++;
        void'(q.pop_front());
      end
      if (acc) begin
        q.push_back(e);
        pushcnt++;
      end
    end
    last_acc = acc;
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4 && q.size() > 0; i++) step();
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int saved;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_addr", out_addr, BASE);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    chk("rst_ready", 32'(in_ready), 32'd1);

    set_req(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFF);
    step(); in_valid = 1'b0;
    chk("i_inst", out_inst, 32'hFFF1_0093);
    chk("i_err", 32'(out_err), 32'd0);
    chk("i_addr", out_addr, BASE);
    step();

    set_req(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8);
    step(); in_valid = 1'b0;
    chk("b8_inst", out_inst, 32'h0020_8463);
    chk("b8_err", 32'(out_err), 32'd0);
    step();
    set_req(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd9);
    step(); in_valid = 1'b0;
    chk("b9_inst", out_inst, 32'h0020_8463);
    chk("b9_err", 32'(out_err), 32'd1);
    step();
    chk("b9_errcnt", 32'(err_count), 32'd1);

    set_req(3'd4, 7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 32'h0001_2345);
    step(); in_valid = 1'b0;
    chk("u_err", 32'(out_err), 32'd1);
    set_req(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 32'd2048);
    step(); in_valid = 1'b0;
    chk("i2048_err", 32'(out_err), 32'd1);
    set_req(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, -32'sd2048);
    step(); in_valid = 1'b0;
    chk("im2048_err", 32'(out_err), 32'd0);
    drain();

    // Backpressure from a clean address origin.
    flush = 1'b1; step(); flush = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(3'd1, 7'b0010011, 5'(k + 1), 5'd4, 5'd0, 3'd0, 32'(k));
      step();
    end
    chk("bp_ready", 32'(in_ready), 32'd0);
    chk("bp_addr0", out_addr, BASE);
    out_ready = 1'b1;
    for (int i = 0; i < 6 && !last_acc; i++) step();
    chk("bp_third_acc", 32'(last_acc), 32'd1);
    drain();

    // Address wrap after DEPTH words.
    flush = 1'b1; step(); flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_req(3'd0, 7'b0110011, 5'(k), 5'd1, 5'd2, 3'd0, 32'd0);
      step();
      if (k == 3) chk("wrap_last", out_addr, BASE + 32'd12);
    end
    chk("wrap_addr", out_addr, BASE);
    drain();

    // Flush with both stages full; err_count must hold.
    out_ready = 1'b0;
    set_req(3'd1, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 32'd4096);
    step(); step();
    saved = m_errcnt;
    flush = 1'b1; step(); flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_errcnt", 32'(err_count), 32'(saved));
    out_ready = 1'b1;
    set_req(3'd0, 7'b0110011, 5'd7, 5'd1, 5'd2, 3'd0, 32'd0);
    step(); in_valid = 1'b0;
    chk("fl_addr", out_addr, BASE);
    drain();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = $urandom & 32'hFFFF_F000;
        default: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      endcase
      set_req(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 3'($urandom), imm);
      in_funct7 = 7'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      step();
    end
    flush = 1'b0;

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    set_req(3'd1, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 32'd5);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_inst", out_inst, 32'd0);
    chk("ar_addr", out_addr, BASE);
    chk("ar_err", 32'(out_err), 32'd0);
    chk("ar_errcnt", 32'(err_count), 32'd0);
    q.delete(); pushcnt = 0; m_errcnt = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    set_req(3'd0, 7'b0110011, 5'd2, 5'd3, 5'd4, 3'd0, 32'd0);
    step(); in_valid = 1'b0;
    chk("ar_next_addr", out_addr, BASE);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
